// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-through data cache.
// Lanes are big-endian: lane 0 is the most significant byte of the word.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_MISS,
        WR_THRU
    } state_t;

    localparam int WORD_BITS = 32;

    function automatic int tag_width(input int address_width, input int set_width);
        return address_width - set_width - 2;
    endfunction

    function automatic logic [WORD_BITS-1:0] lane_select(
        input logic [WORD_BITS-1:0] word,
        input logic [1:0]           lane,
        input logic                 is_byte
    );
        logic [7:0] sel;
        case (lane)
            2'd0:    sel = word[31:24];
            2'd1:    sel = word[23:16];
            2'd2:    sel = word[15:8];
            default: sel = word[7:0];
        endcase
        return is_byte ? {24'h000000, sel} : word;
    endfunction

    function automatic logic [WORD_BITS-1:0] byte_merge(
        input logic [WORD_BITS-1:0] word,
        input logic [1:0]           lane,
        input logic [7:0]           data
    );
        logic [WORD_BITS-1:0] merged;
        merged = word;
        case (lane)
            2'd0:    merged[31:24] = data;
            2'd1:    merged[23:16] = data;
            2'd2:    merged[15:8]  = data;
            default: merged[7:0]   = data;
        endcase
        return merged;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag and data storage for the cache lines: asynchronous read, synchronous write.
// Valid bits are kept outside so they can be cleared by the asynchronous reset.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int SET_WIDTH  = 8,
    parameter int TAG_WIDTH  = 22,
    parameter int DATA_WIDTH = WORD_BITS
) (
    input  logic                  clk,
    input  logic [SET_WIDTH-1:0]  index,
    output logic [TAG_WIDTH-1:0]  line_tag,
    output logic [DATA_WIDTH-1:0] line_data,
    input  logic                  write_en,
    input  logic [TAG_WIDTH-1:0]  write_tag,
    input  logic [DATA_WIDTH-1:0] write_data
);

    localparam int SETS = 2 ** SET_WIDTH;

    logic [TAG_WIDTH-1:0]  tags  [SETS];
    logic [DATA_WIDTH-1:0] words [SETS];

    always_ff @(posedge clk) begin
        if (write_en) begin
            tags[index]  <= write_tag;
            words[index] <= write_data;
        end
    end

    assign line_tag  = tags[index];
    assign line_data = words[index];

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache between the CPU
// memory stage and a req/ack backing memory; read hits complete in zero cycles.
module dcache_wt
    import dcache_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = WORD_BITS,
    parameter int SET_WIDTH     = 8,
    parameter int TAG_WIDTH     = tag_width(ADDRESS_WIDTH, SET_WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic                     cpu_byte,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    output logic                     stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic                     mem_byte,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    input  logic                     mem_ack,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
);

    localparam int SETS = 2 ** SET_WIDTH;

    state_t                  state;
    logic [SETS-1:0]         valid;
    logic [SET_WIDTH-1:0]    index;
    logic [TAG_WIDTH-1:0]    tag;
    logic [1:0]              lane;
    logic [TAG_WIDTH-1:0]    line_tag;
    logic [DATA_WIDTH-1:0]   line_data;
    logic                    hit;
    logic                    load_req;
    logic                    store_req;
    logic                    line_we;
    logic [DATA_WIDTH-1:0]   line_wdata;
    logic                    stall_raw;

    assign index     = cpu_addr[SET_WIDTH+1:2];
    assign tag       = cpu_addr[ADDRESS_WIDTH-1:SET_WIDTH+2];
    assign lane      = cpu_addr[1:0];
    assign hit       = valid[index] && (line_tag == tag);
    assign load_req  = cpu_req && !cpu_we;
    assign store_req = cpu_req && cpu_we;

    dcache_array #(
        .SET_WIDTH  (SET_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk        (clk),
        .index      (index),
        .line_tag   (line_tag),
        .line_data  (line_data),
        .write_en   (line_we),
        .write_tag  (tag),
        .write_data (line_wdata)
    );

    // The CPU holds its inputs while stalled, so the memory side can be
    // driven straight from them rather than from captured copies.
    always_comb begin
        stall_raw  = 1'b0;
        line_we    = 1'b0;
        line_wdata = mem_rdata;
        cpu_rdata  = lane_select(line_data, lane, cpu_byte);
        mem_byte   = 1'b0;
        mem_addr   = {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
        mem_wdata  = cpu_wdata;
        case (state)
            IDLE: begin
                stall_raw = store_req || (load_req && !hit);
            end
            RD_MISS: begin
                stall_raw = !mem_ack;
                cpu_rdata = lane_select(mem_rdata, lane, cpu_byte);
                line_we   = mem_ack;
            end
            WR_THRU: begin
                stall_raw  = !mem_ack;
                mem_byte   = cpu_byte;
                mem_addr   = cpu_addr;
                line_we    = mem_ack && hit;
                line_wdata = cpu_byte ? byte_merge(line_data, lane, cpu_wdata[7:0])
                                      : cpu_wdata;
            end
            default: ;
        endcase
    end

    // Reset must release the pipeline at once even if a request is still held.
    assign stall = stall_raw && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            valid      <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (store_req) begin
                        state   <= WR_THRU;
                        mem_req <= 1'b1;
                        mem_we  <= 1'b1;
                    end else if (load_req) begin
                        if (hit) begin
                            hit_count <= sat_inc(hit_count);
                        end else begin
                            state      <= RD_MISS;
                            mem_req    <= 1'b1;
                            mem_we     <= 1'b0;
                            miss_count <= sat_inc(miss_count);
                        end
                    end
                end
                RD_MISS: begin
                    if (mem_ack) begin
                        state        <= IDLE;
                        mem_req      <= 1'b0;
                        mem_we       <= 1'b0;
                        valid[index] <= 1'b1;
                    end
                end
                WR_THRU: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_wt.sv
// Self-checking bench for dcache_wt: directed vector table, reset corner case,
// and randomized traffic against a memory-plus-tag reference model.
module tb_dcache_wt;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic        cpu_byte;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic        mem_byte;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    dcache_wt dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_byte   (cpu_byte),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_byte   (mem_byte),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        bit          is_byte;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp_rdata;
        int          exp_stalls;
        int          exp_hits;
        int          exp_misses;
    } vec_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] mem_model [logic [31:0]];
    bit          ref_valid [256];
    logic [21:0] ref_tag   [256];

    int          obs_stalls;
    bit          obs_done;
    bit          obs_req_seen;
    logic [31:0] obs_rdata;
    logic        obs_mem_we;
    logic        obs_mem_byte;
    logic [31:0] obs_mem_addr;
    logic [31:0] obs_mem_wdata;

    function automatic logic [31:0] mem_read(input logic [31:0] addr);
        logic [31:0] w;
        w = {addr[31:2], 2'b00};
        if (mem_model.exists(w)) return mem_model[w];
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    function automatic void mem_write(input logic [31:0] addr, input bit is_byte,
                                      input logic [31:0] data);
        logic [31:0] w;
        int          sh;
        w  = mem_read(addr);
        sh = 8 * (3 - int'(addr[1:0]));
        if (is_byte) w = (w & ~(32'hFF << sh)) | ({24'h0, data[7:0]} << sh);
        else         w = data;
        mem_model[{addr[31:2], 2'b00}] = w;
    endfunction

    function automatic logic [31:0] pick(input logic [31:0] w, input logic [31:0] addr,
                                         input bit is_byte);
        if (!is_byte) return w;
        return (w >> (8 * (3 - int'(addr[1:0])))) & 32'hFF;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    // Presents one access at posedge+1 and plays the memory with a fixed
    // latency; returns at posedge+1 after the completing edge.
    task automatic apply_stimulus(input bit we, input bit is_byte, input logic [31:0] addr,
                                  input logic [31:0] wdata, input int lat);
        int wait_cnt;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_byte  = is_byte;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        wait_cnt      = 0;
        obs_done      = 1'b0;
        obs_stalls    = 0;
        obs_req_seen  = 1'b0;
        obs_rdata     = '0;
        obs_mem_we    = 1'b0;
        obs_mem_byte  = 1'b0;
        obs_mem_addr  = '0;
        obs_mem_wdata = '0;
        for (int c = 0; c < 64 && !obs_done; c++) begin
            mem_ack = 1'b0;
            if (mem_req) begin
                obs_req_seen = 1'b1;
                if (wait_cnt == lat) begin
                    mem_ack       = 1'b1;
                    mem_rdata     = mem_read(mem_addr);
                    obs_mem_we    = mem_we;
                    obs_mem_byte  = mem_byte;
                    obs_mem_addr  = mem_addr;
                    obs_mem_wdata = mem_wdata;
                end else begin
                    wait_cnt++;
                end
            end
            #1;
            if (stall) obs_stalls++;
            else begin
                obs_done  = 1'b1;
                obs_rdata = cpu_rdata;
            end
            @(posedge clk);
            #1;
        end
        cpu_req = 1'b0;
        mem_ack = 1'b0;
        check_output("access completes", 32'(obs_done), 32'd1);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) ref_valid[i] = 1'b0;
    endtask

    vec_t vecs [14];

    initial begin
        logic [31:0] a;
        logic [31:0] exp_r;
        bit          we;
        bit          is_b;
        bit          hit;
        int          lat;
        int          exp_stalls;
        int          exp_hits;
        int          exp_misses;
        logic [31:0] wd;

        rst_n = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_byte = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        mem_model[32'h0001_0000] = 32'hDEAD_BEEF;
        mem_model[32'h0002_0400] = 32'h1122_3344;

        //           we byte addr          wdata         lat rdata          stall hits miss
        vecs[0]  = '{0, 0, 32'h0001_0000, 32'h0,        3, 32'hDEAD_BEEF, 4, 0, 1};
        vecs[1]  = '{0, 0, 32'h0001_0000, 32'h0,        3, 32'hDEAD_BEEF, 0, 1, 1};
        vecs[2]  = '{1, 1, 32'h0001_0002, 32'h55,       2, 32'h0,         3, 1, 1};
        vecs[3]  = '{0, 0, 32'h0001_0000, 32'h0,        1, 32'hDEAD_55EF, 0, 2, 1};
        vecs[4]  = '{1, 0, 32'h0001_0400, 32'h1234_5678, 1, 32'h0,        2, 2, 1};
        vecs[5]  = '{0, 0, 32'h0001_0000, 32'h0,        1, 32'hDEAD_55EF, 0, 3, 1};
        vecs[6]  = '{0, 0, 32'h0001_0400, 32'h0,        0, 32'h1234_5678, 1, 3, 2};
        vecs[7]  = '{0, 0, 32'h0001_0000, 32'h0,        2, 32'hDEAD_55EF, 3, 3, 3};
        vecs[8]  = '{0, 1, 32'h0001_0003, 32'h0,        1, 32'h0000_00EF, 0, 4, 3};
        vecs[9]  = '{0, 1, 32'h0001_0001, 32'h0,        1, 32'h0000_00AD, 0, 5, 3};
        vecs[10] = '{1, 0, 32'h0001_0000, 32'hCAFE_F00D, 0, 32'h0,        1, 5, 3};
        vecs[11] = '{0, 0, 32'h0001_0000, 32'h0,        1, 32'hCAFE_F00D, 0, 6, 3};
        vecs[12] = '{0, 1, 32'h0002_0401, 32'h0,        1, 32'h0000_0022, 2, 6, 4};
        vecs[13] = '{0, 1, 32'h0001_0000, 32'h0,        0, 32'h0000_00CA, 1, 6, 5};

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset stall", 32'(stall), 32'd0);
        check_output("reset mem_req", 32'(mem_req), 32'd0);
        check_output("reset hit_count", hit_count, 32'd0);
        check_output("reset miss_count", miss_count, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            apply_stimulus(vecs[i].we, vecs[i].is_byte, vecs[i].addr, vecs[i].wdata, vecs[i].lat);
            if (vecs[i].we) begin
                mem_write(vecs[i].addr, vecs[i].is_byte, vecs[i].wdata);
                check_output($sformatf("v%0d mem_we", i), 32'(obs_mem_we), 32'd1);
                check_output($sformatf("v%0d mem_byte", i), 32'(obs_mem_byte), 32'(vecs[i].is_byte));
                check_output($sformatf("v%0d mem_addr", i), obs_mem_addr, vecs[i].addr);
                check_output($sformatf("v%0d mem_wdata", i), obs_mem_wdata, vecs[i].wdata);
            end else begin
                check_output($sformatf("v%0d rdata", i), obs_rdata, vecs[i].exp_rdata);
                if (vecs[i].exp_stalls == 0) begin
                    check_output($sformatf("v%0d hit mem_req", i), 32'(obs_req_seen), 32'd0);
                end else begin
                    check_output($sformatf("v%0d fill addr", i), obs_mem_addr,
                                 {vecs[i].addr[31:2], 2'b00});
                    check_output($sformatf("v%0d fill we/byte", i),
                                 32'({obs_mem_we, obs_mem_byte}), 32'd0);
                end
            end
            check_output($sformatf("v%0d stalls", i), 32'(obs_stalls), 32'(vecs[i].exp_stalls));
            check_output($sformatf("v%0d hit_count", i), hit_count, 32'(vecs[i].exp_hits));
            check_output($sformatf("v%0d miss_count", i), miss_count, 32'(vecs[i].exp_misses));
        end

        // Reset in the middle of a fill, then a stray ack after release.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = 32'h0003_0000;
        repeat (2) @(posedge clk);
        #1;
        check_output("mid fill mem_req", 32'(mem_req), 32'd1);
        check_output("mid fill stall", 32'(stall), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_output("async rst mem_req", 32'(mem_req), 32'd0);
        check_output("async rst stall", 32'(stall), 32'd0);
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        check_output("late ack mem_req", 32'(mem_req), 32'd0);
        check_output("late ack miss_count", miss_count, 32'd0);
        apply_stimulus(1'b0, 1'b0, 32'h0003_0000, 32'h0, 1);
        check_output("post rst stalls", 32'(obs_stalls), 32'd2);
        check_output("post rst rdata", obs_rdata, mem_read(32'h0003_0000));
        check_output("post rst miss_count", miss_count, 32'd1);

        // Random traffic over 8 sets x 4 tags so hits, misses and evictions mix.
        reset_dut();
        exp_hits   = 0;
        exp_misses = 0;
        for (int n = 0; n < 400; n++) begin
            is_b = 1'($urandom_range(0, 1));
            we   = ($urandom_range(0, 3) == 0);
            lat  = int'($urandom_range(0, 3));
            wd   = $urandom;
            a    = 32'h0008_0000 + (32'($urandom_range(0, 3)) << 10)
                 + (32'($urandom_range(0, 7)) << 2)
                 + (is_b ? 32'($urandom_range(0, 3)) : 32'd0);
            hit  = ref_valid[a[9:2]] && (ref_tag[a[9:2]] == a[31:10]);
            exp_r = pick(mem_read(a), a, is_b);
            if (we) exp_stalls = lat + 1;
            else    exp_stalls = hit ? 0 : lat + 1;
            apply_stimulus(we, is_b, a, wd, lat);
            check_output($sformatf("r%0d stalls", n), 32'(obs_stalls), 32'(exp_stalls));
            if (we) begin
                mem_write(a, is_b, wd);
                check_output($sformatf("r%0d store addr", n), obs_mem_addr, a);
                check_output($sformatf("r%0d store byte", n), 32'(obs_mem_byte), 32'(is_b));
            end else begin
                check_output($sformatf("r%0d rdata", n), obs_rdata, exp_r);
                if (hit) exp_hits++;
                else begin
                    exp_misses++;
                    ref_valid[a[9:2]] = 1'b1;
                    ref_tag[a[9:2]]   = a[31:10];
                end
            end
        end
        check_output("random hit_count", hit_count, 32'(exp_hits));
        check_output("random miss_count", miss_count, 32'(exp_misses));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the CPU memory stage and the backing data memory.
- Holds the pipeline with `stall` on misses and writes. Serves read hits in zero cycles.
- Talks to memory over a req/ack handshake, so backing memory may take any number of cycles.

Parameters:
- ADDRESS_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width
- SET_WIDTH, 8, index bits; 2**SET_WIDTH lines of one word each
- TAG_WIDTH, ADDRESS_WIDTH-SET_WIDTH-2, tag bits per line

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  valid load/store this cycle
- cpu_we  in  1  1 = store, 0 = load
- cpu_byte  in  1  1 = byte access, 0 = word access
- cpu_addr  in  ADDRESS_WIDTH  byte address
- cpu_wdata  in  DATA_WIDTH  store data; byte stores use [7:0]
- cpu_rdata  out  DATA_WIDTH  load data; byte loads zero-extended
- stall  out  1  CPU must hold all cpu_* inputs stable while high
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write
- mem_byte  out  1  memory byte access
- mem_addr  out  ADDRESS_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory word read data, valid with mem_ack
- mem_ack  in  1  single-cycle completion pulse
- hit_count  out  32  saturating count of read hits
- miss_count  out  32  saturating count of read misses

Behaviour:
- Address split: index = addr[SET_WIDTH+1:2]; tag = addr[ADDRESS_WIDTH-1:SET_WIDTH+2]; lane = addr[1:0].
- Byte order is big-endian: lane 0 = word[31:24], lane 3 = word[7:0].
- Reset (asynchronous, rst_n low):
  - state = IDLE; all valid bits = 0.
  - mem_req = 0; stall = 0; hit_count = miss_count = 0.
  - Takes effect immediately, including mid-transaction; an in-flight mem_ack after reset is ignored.
- Outputs in IDLE with no request: stall = 0, mem_req = 0.
- cpu_rdata is combinational and is don't-care when no load completes.
- FSM states: IDLE, RD_MISS, WR_THRU.
- IDLE, load hit (valid and tag match):
  - cpu_rdata = selected word or lane from the line; stall = 0; hit_count += 1.
  - Stay in IDLE.
- IDLE, load miss:
  - stall = 1 combinationally; go to RD_MISS; miss_count += 1.
- IDLE, store:
  - stall = 1; go to WR_THRU.
- RD_MISS:
  - mem_req = 1, mem_we = 0, mem_byte = 0, mem_addr = {addr[31:2], 2'b00}.
  - stall = 1 until mem_ack.
  - On the mem_ack cycle:
    - Write the line: data = mem_rdata, tag updated, valid = 1.
    - cpu_rdata is driven from mem_rdata (lane-selected for byte loads).
    - stall = 0; return to IDLE.
  - Latency = memory latency + 1 cycle.
- WR_THRU:
  - mem_req = 1, mem_we = 1, mem_byte = cpu_byte, mem_addr = cpu_addr, mem_wdata = cpu_wdata.
  - On the mem_ack cycle:
    - If hit, update the line: word store replaces the word; byte store merges cpu_wdata[7:0] into its lane only.
    - If miss, leave the cache unchanged.
    - stall = 0; return to IDLE.
- A request presented in the same cycle stall falls is treated as the next access. Its response follows the IDLE rules, evaluated against the line state after this edge's update.
- mem_req never drops before mem_ack. mem_ack while mem_req = 0 is ignored.
- Counters stop at 32'hFFFFFFFF and do not wrap.

Decomposition:
- Package dcache_pkg holds:
  - state enum {IDLE, RD_MISS, WR_THRU}
  - lane-select function
  - byte-merge function
  - TAG_WIDTH derivation
- Sub-module dcache_array:
  - data and tag storage with asynchronous read and synchronous write.
  - Valid bits live in the top level as a flop vector so reset can clear them asynchronously.

Test Plan:
- Reset then load word 0x10000 (mem_rdata = 0xDEADBEEF after 3 cycles) -> stall for 4 cycles; cpu_rdata = 0xDEADBEEF on the ack cycle; miss_count = 1.
- Repeat the same load -> stall = 0, cpu_rdata = 0xDEADBEEF in the same cycle, no mem_req; hit_count = 1.
- Byte store 0x55 to 0x10002 after that fill -> memory sees mem_byte = 1, addr 0x10002; the following word load hits and returns 0xDEAD55EF.
- Store to uncached 0x10400 -> write goes through to memory; the following load of 0x10400 misses (no allocate).
- Load 0x10000 then 0x10400 (same index, different tag) -> second access misses and evicts; a reload of 0x10000 misses again.
- Assert rst_n low during RD_MISS before ack -> mem_req = 0 and stall = 0 immediately; a late mem_ack is ignored; the next load of the same address misses.
